axi_llc_data_way_pipe: RTL and testbench
========================================

Name: axi_llc_data_way_pipe

Overview:
Next-generation LLC data-way controller: drives one data SRAM macro of configurable read latency and pipelines back-to-back reads without stalling. Read responses, tagged with the requesting cache unit, go through an internal credit-protected output FIFO, so downstream back-pressure never loses macro data. Sits between the way demux in axi_llc_ways and an external SRAM macro (ECC lives in the macro wrapper).

Parameters:
AddrWidth, 10, SRAM word address width (index ++ block offset)
DataWidth, 64, SRAM word width in bits; multiple of 8
UnitWidth, 2, width of the cache_unit tag (axi_llc_pkg::cache_unit_e)
Latency, 1, SRAM read latency in cycles; legal 1..8
FifoDepth, 2, output FIFO entries; legal >= 1; FifoDepth >= Latency gives full throughput

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous reset, active low
test_i  in  1  test mode, forwarded to FIFO
inp_valid_i  in  1  request valid
inp_ready_o  out  1  request accepted when valid&&ready
inp_unit_i  in  UnitWidth  requesting cache unit
inp_addr_i  in  AddrWidth  word address
inp_we_i  in  1  1 = write, 0 = read
inp_data_i  in  DataWidth  write data
inp_strb_i  in  DataWidth/8  byte enables
out_valid_o  out  1  read response valid
out_ready_i  in  1  downstream ready
out_unit_o  out  UnitWidth  unit tag of response
out_data_o  out  DataWidth  read data
out_err_i  in  1  macro multi-bit error, aligned with ram_rdata_i
out_err_o  out  1  error flag of response
ram_req_o  out  1  macro request
ram_we_o  out  1  macro write enable
ram_addr_o  out  AddrWidth  macro address
ram_wdata_o  out  DataWidth  macro write data
ram_be_o  out  DataWidth/8  macro byte enables
ram_gnt_i  in  1  macro grant, combinational
ram_rdata_i  in  DataWidth  macro read data, valid Latency cycles after granted read
busy_o  out  1  reads in flight or FIFO non-empty

Behaviour:
- Single clock domain; clock clk_i; reset rst_ni, asynchronous, active low.
- Reset: inp_ready_o follows combinational rules (0 while ram_gnt_i=0); out_valid_o=0, out_unit_o=0 (EvictUnit), out_data_o=0, out_err_o=0, ram_req_o=0, busy_o=0; pipeline and FIFO empty, credit counter = FifoDepth.
- ram_we_o/addr/wdata/be driven combinationally from inp_*; ram_req_o = inp_valid_i && inp_ready_o.
- Credits: credit = FifoDepth - fifo_count - inflight_reads. pop = out_valid_o && out_ready_i.
- Write: inp_ready_o = ram_gnt_i; consumes no credit; produces no response.
- Read: inp_ready_o = ram_gnt_i && (credit > 0 || pop); same-cycle pop frees a credit.
- Accepted read (cycle 0) enters shift pipeline {valid, unit} of depth Latency; at cycle Latency, ram_rdata_i/out_err_i plus unit are pushed into FIFO.
- FIFO is fall-through: with empty FIFO, out_valid_o=1 in cycle Latency (Latency=1 -> response the cycle after accept). Response held stable until pop.
- Back-to-back reads: with FifoDepth >= Latency and out_ready_i=1, one read accepted per cycle sustained; responses strictly in acceptance order.
- Push into full FIFO is impossible by credit rule; assertion fires if it happens.
- Interleaved writes do not disturb read pipeline ordering.
- ram_gnt_i=0: inp_ready_o=0; pipeline and FIFO keep advancing/draining.
- inflight_reads counter width clog2(Latency+1); increments on accepted read, decrements on pipeline exit, both in same cycle -> unchanged.
- busy_o = inflight_reads != 0 || fifo_count != 0.
- Reset asserted mid-operation: in-flight reads and buffered responses dropped; no response after release.
- Assertions: Latency in 1..8, FifoDepth >= 1, DataWidth % 8 == 0; out_* stable while out_valid_o && !out_ready_i.

Decomposition:
- axi_llc_pkg: cache_unit_e, new constant DataMacroLatencyMax = 8; DataMacroLatency becomes the default of Latency.
- Sub-module: common_cells fifo_v3 (FALL_THROUGH=1, DEPTH=FifoDepth) for responses; pipeline and credit logic local, registers via FFARN/FFLARN.

Test Plan:
- Latency=1, FifoDepth=2: read addr 0x10 unit=RefilUnit after write 0xDEADBEEF strb all -> out_valid_o in cycle 1, out_data_o=0xDEADBEEF, out_unit_o=RefilUnit.
- Latency=3, FifoDepth=3, out_ready_i=1: 16 back-to-back reads -> inp_ready_o constantly 1, 16 responses in order, first at cycle 3, last at cycle 18.
- Latency=2, FifoDepth=2, out_ready_i=0: issue reads -> exactly 2 accepted, then inp_ready_o=0 for reads while writes still accepted; raise out_ready_i -> 2 responses in order, reads resume.
- ram_gnt_i toggled 1/0 each cycle on a 10-read stream -> no duplicate or lost responses, order preserved, ram_req_o only when ram_gnt_i=1.
- out_err_i=1 on 3rd read's data beat -> only 3rd response has out_err_o=1.
- Reset pulsed with 2 reads in flight and 1 buffered -> out_valid_o=0, busy_o=0 immediately; no responses after release; next read returns correct data.

Source files
------------

// File: rtl/axi_llc_data_way_pipe_pkg.sv
// axi_llc_data_way_pipe_pkg: cache unit tags and data macro latency limits
package axi_llc_data_way_pipe_pkg;
  typedef enum logic [1:0] {EvictUnit = 2'd0, RefilUnit = 2'd1, RWUnit = 2'd2} cache_unit_e;
  localparam int DataMacroLatency = 1;
  localparam int DataMacroLatencyMax = 8;
endpackage

// File: rtl/axi_llc_data_way_pipe_fifo.sv
// axi_llc_data_way_pipe_fifo: fall-through response FIFO with occupancy count
module axi_llc_data_way_pipe_fifo
  import axi_llc_data_way_pipe_pkg::*;
#(
  parameter int Width = 8,
  parameter int Depth = 2,
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             test_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o
);
  localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;
  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0] rptr_q, wptr_q;
  logic [CntW-1:0] cnt_q;
  logic empty, store, take, test_unused;
  assign test_unused = test_i;
  assign empty = cnt_q == '0;
  assign valid_o = !empty || push_i;
  assign data_o = !empty ? mem_q[rptr_q] : (push_i ? data_i : '0);
  // an empty FIFO hands a same-cycle push straight to the consumer
  assign store = push_i && !(empty && pop_i);
  assign take = pop_i && !empty;
  assign count_o = cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (store) wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
      if (take) rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
      if (store != take) cnt_q <= store ? cnt_q + CntW'(1) : cnt_q - CntW'(1);
    end
  always_ff @(posedge clk_i)
    if (store) mem_q[wptr_q] <= data_i;
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && cnt_q == CntW'(Depth)));
endmodule

// File: rtl/axi_llc_data_way_pipe.sv
// axi_llc_data_way_pipe: data SRAM way controller with pipelined reads and credit-protected response FIFO
module axi_llc_data_way_pipe
  import axi_llc_data_way_pipe_pkg::*;
#(
  parameter int AddrWidth = 10,
  parameter int DataWidth = 64,
  parameter int UnitWidth = 2,
  parameter int Latency = DataMacroLatency,
  parameter int FifoDepth = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   test_i,
  input  logic                   inp_valid_i,
  output logic                   inp_ready_o,
  input  logic [UnitWidth-1:0]   inp_unit_i,
  input  logic [AddrWidth-1:0]   inp_addr_i,
  input  logic                   inp_we_i,
  input  logic [DataWidth-1:0]   inp_data_i,
  input  logic [DataWidth/8-1:0] inp_strb_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [UnitWidth-1:0]   out_unit_o,
  output logic [DataWidth-1:0]   out_data_o,
  input  logic                   out_err_i,
  output logic                   out_err_o,
  output logic                   ram_req_o,
  output logic                   ram_we_o,
  output logic [AddrWidth-1:0]   ram_addr_o,
  output logic [DataWidth-1:0]   ram_wdata_o,
  output logic [DataWidth/8-1:0] ram_be_o,
  input  logic                   ram_gnt_i,
  input  logic [DataWidth-1:0]   ram_rdata_i,
  output logic                   busy_o
);
  localparam int IfW = $clog2(Latency + 1);
  localparam int CntW = $clog2(FifoDepth + 1);
  localparam int RspW = 1 + UnitWidth + DataWidth;
  logic [Latency-1:0] vld_q;
  logic [Latency-1:0][UnitWidth-1:0] unit_q;
  logic [IfW-1:0] inflight_q;
  logic [CntW-1:0] fifo_count;
  logic [RspW-1:0] rsp_data;
  logic pop, rd_acc, exit_rd, credit_ok;
  assign pop = out_valid_o && out_ready_i;
  // every read reserves a FIFO slot at accept time so the macro data always has a home
  assign credit_ok = 32'(fifo_count) + 32'(inflight_q) < 32'(FifoDepth);
  assign inp_ready_o = ram_gnt_i && (inp_we_i || credit_ok || pop);
  assign ram_req_o = inp_valid_i && inp_ready_o;
  assign ram_we_o = inp_we_i;
  assign ram_addr_o = inp_addr_i;
  assign ram_wdata_o = inp_data_i;
  assign ram_be_o = inp_strb_i;
  assign rd_acc = ram_req_o && !inp_we_i;
  assign exit_rd = vld_q[Latency-1];
  assign busy_o = inflight_q != '0 || fifo_count != '0;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      vld_q <= '0;
      unit_q <= '0;
      inflight_q <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      unit_q[0] <= inp_unit_i;
      for (int i = 1; i < Latency; i++) begin
        vld_q[i] <= vld_q[i-1];
        unit_q[i] <= unit_q[i-1];
      end
      if (rd_acc != exit_rd) inflight_q <= rd_acc ? inflight_q + IfW'(1) : inflight_q - IfW'(1);
    end
  axi_llc_data_way_pipe_fifo #(.Width(RspW), .Depth(FifoDepth)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .test_i  (test_i),
    .push_i  (exit_rd),
    .data_i  ({out_err_i, unit_q[Latency-1], ram_rdata_i}),
    .pop_i   (pop),
    .valid_o (out_valid_o),
    .data_o  (rsp_data),
    .count_o (fifo_count)
  );
  assign {out_err_o, out_unit_o, out_data_o} = rsp_data;
  assert property (@(posedge clk_i)
    Latency >= 1 && Latency <= DataMacroLatencyMax && FifoDepth >= 1 && DataWidth % 8 == 0);
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_valid_o && !out_ready_i |=> out_valid_o && $stable({out_unit_o, out_data_o, out_err_o}));
endmodule

// File: tb/tb_axi_llc_data_way_pipe.sv
// tb_axi_llc_data_way_pipe: scoreboard bench with a latency-accurate SRAM macro model
module tb_axi_llc_data_way_pipe;
  import axi_llc_data_way_pipe_pkg::*;
  localparam int AW = 10, DW = 64, UW = 2, L = 2, D = 3, SW = DW / 8;
  typedef struct packed {
    logic err;
    logic [UW-1:0] unit;
    logic [DW-1:0] data;
  } rsp_t;
  logic clk_i = 1'b0, rst_ni = 1'b0, test_i = 1'b0;
  logic inp_valid_i = 1'b0, inp_we_i = 1'b0, out_ready_i = 1'b1, ram_gnt_i = 1'b0;
  logic [UW-1:0] inp_unit_i = '0;
  logic [AW-1:0] inp_addr_i = '0;
  logic [DW-1:0] inp_data_i = '0;
  logic [SW-1:0] inp_strb_i = '0;
  logic inp_ready_o, out_valid_o, out_err_i, out_err_o, ram_req_o, ram_we_o, busy_o;
  logic [UW-1:0] out_unit_o;
  logic [DW-1:0] out_data_o, ram_wdata_o, ram_rdata_i;
  logic [AW-1:0] ram_addr_o;
  logic [SW-1:0] ram_be_o;
  int total = 0, bad = 0, resp_n = 0, last_resp_cyc = 0, cyc = 0;
  rsp_t sb[$];
  logic [DW-1:0] ref_mem [1<<AW];
  logic [DW-1:0] sram [1<<AW];
  logic [DW-1:0] rd_pipe [L];
  logic [L-1:0] err_pipe;
  logic next_err = 1'b0, init_done = 1'b0;

  axi_llc_data_way_pipe #(
    .AddrWidth(AW), .DataWidth(DW), .UnitWidth(UW), .Latency(L), .FifoDepth(D)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_i(test_i),
    .inp_valid_i(inp_valid_i), .inp_ready_o(inp_ready_o), .inp_unit_i(inp_unit_i),
    .inp_addr_i(inp_addr_i), .inp_we_i(inp_we_i), .inp_data_i(inp_data_i), .inp_strb_i(inp_strb_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_unit_o(out_unit_o),
    .out_data_o(out_data_o), .out_err_i(out_err_i), .out_err_o(out_err_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o), .ram_gnt_i(ram_gnt_i),
    .ram_rdata_i(ram_rdata_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pattern(input int i);
    return {32'(i) * 32'h9E37_79B9, ~32'(i)};
  endfunction

  // macro model: read data and error appear L cycles after a granted read
  always @(posedge clk_i) begin
    if (!init_done) begin
      for (int i = 0; i < (1 << AW); i++) sram[i] <= pattern(i);
      init_done <= 1'b1;
    end else if (ram_req_o && ram_we_o)
      for (int b = 0; b < SW; b++) if (ram_be_o[b]) sram[ram_addr_o][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
    rd_pipe[0] <= (ram_req_o && !ram_we_o) ? sram[ram_addr_o] : '0;
    err_pipe[0] <= ram_req_o && !ram_we_o && next_err;
    for (int i = 1; i < L; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
      err_pipe[i] <= err_pipe[i-1];
    end
  end
  assign ram_rdata_i = rd_pipe[L-1];
  assign out_err_i = err_pipe[L-1];

  task automatic monitor_rsp();
    rsp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && ram_req_o) begin
        total++;
        if (!ram_gnt_i) begin bad++; $display("FAIL ram_req_gnt: ram_req_o=1 with ram_gnt_i=0, required ram_req_o=0"); end
      end
      if (rst_ni && out_valid_o && out_ready_i) begin
        total++;
        resp_n++;
        last_resp_cyc = cyc;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected: got unit=%0d data=%h err=%b, required no response", out_unit_o, out_data_o, out_err_o);
        end else begin
          e = sb.pop_front();
          if ({out_err_o, out_unit_o, out_data_o} !== e) begin
            bad++;
            $display("FAIL rsp: got err=%b unit=%0d data=%h, required err=%b unit=%0d data=%h",
                     out_err_o, out_unit_o, out_data_o, e.err, e.unit, e.data);
          end
        end
      end
    end
  endtask

  // one request per cycle; acceptance is judged at the falling edge
  task automatic step(input logic we, input logic [UW-1:0] u, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [SW-1:0] s, input logic e, output logic acc);
    rsp_t r;
    inp_valid_i = 1'b1; inp_we_i = we; inp_unit_i = u; inp_addr_i = a;
    inp_data_i = d; inp_strb_i = s; next_err = e;
    @(negedge clk_i);
    acc = inp_ready_o;
    if (acc && we) for (int b = 0; b < SW; b++) if (s[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
    if (acc && !we) begin
      r = {e, u, ref_mem[a]};
      sb.push_back(r);
    end
    @(posedge clk_i); #1;
    inp_valid_i = 1'b0; next_err = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    out_ready_i = 1'b1;
    while ((sb.size() != 0 || busy_o) && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    total++;
    if (sb.size() != 0 || busy_o) begin
      bad++;
      $display("FAIL %s_drain: pending=%0d busy=%b, required pending=0 busy=0", tag, sb.size(), busy_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; ram_gnt_i = 1'b0; inp_valid_i = 1'b1; inp_we_i = 1'b0;
    repeat (3) @(posedge clk_i); #1;
    total++;
    if ({inp_ready_o, ram_req_o} !== 2'b00) begin
      bad++; $display("FAIL rst_ready: got ready=%b req=%b, required 0 0", inp_ready_o, ram_req_o);
    end
    inp_valid_i = 1'b0; #1;
    total++;
    if ({out_valid_o, out_unit_o, out_data_o, out_err_o, ram_req_o, busy_o} !== '0) begin
      bad++;
      $display("FAIL rst_outputs: got valid=%b unit=%0d data=%h err=%b req=%b busy=%b, required all 0",
               out_valid_o, out_unit_o, out_data_o, out_err_o, ram_req_o, busy_o);
    end
    rst_ni = 1'b1; ram_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    total++;
    if ({out_valid_o, busy_o, inp_ready_o} !== 3'b001) begin
      bad++; $display("FAIL rst_release: got valid=%b busy=%b ready=%b, required 0 0 1", out_valid_o, busy_o, inp_ready_o);
    end
  endtask

  task automatic test_single();
    logic acc;
    logic early = 1'b0;
    step(1'b1, EvictUnit, 10'h10, 64'h0000_0000_DEAD_BEEF, '1, 1'b0, acc);
    total++;
    if (acc !== 1'b1) begin bad++; $display("FAIL single_write_acc: got %b, required 1", acc); end
    step(1'b0, RefilUnit, 10'h10, '0, '0, 1'b0, acc);
    total++;
    if (acc !== 1'b1) begin bad++; $display("FAIL single_read_acc: got %b, required 1", acc); end
    for (int i = 1; i < L; i++) begin
      @(negedge clk_i);
      if (out_valid_o) early = 1'b1;
    end
    total++;
    if (early !== 1'b0) begin bad++; $display("FAIL single_early: got out_valid before cycle %0d, required none", L); end
    @(negedge clk_i);
    total++;
    if ({out_valid_o, out_unit_o, out_data_o} !== {1'b1, RefilUnit, 64'h0000_0000_DEAD_BEEF}) begin
      bad++;
      $display("FAIL single_rsp: got valid=%b unit=%0d data=%h, required 1 %0d deadbeef", out_valid_o, out_unit_o, out_data_o, RefilUnit);
    end
    @(posedge clk_i); #1;
    drain("single");
  endtask

  task automatic test_back_to_back();
    logic acc;
    int start, r0, nrdy = 0;
    r0 = resp_n; start = cyc; out_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, UW'(i % 3), AW'(10'h100 + i), '0, '0, 1'b0, acc);
      if (!acc) nrdy++;
    end
    total++;
    if (nrdy !== 0) begin bad++; $display("FAIL b2b_ready: got %0d stalled cycles, required 0", nrdy); end
    drain("b2b");
    total++;
    if (resp_n - r0 !== 16) begin bad++; $display("FAIL b2b_count: got %0d responses, required 16", resp_n - r0); end
    total++;
    if (last_resp_cyc !== start + 15 + L) begin
      bad++; $display("FAIL b2b_last: got cycle %0d, required %0d", last_resp_cyc - start, 15 + L);
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    int nacc = 0, r0;
    r0 = resp_n; out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, RWUnit, AW'(10'h200 + i), '0, '0, 1'b0, acc);
      if (acc) nacc++;
    end
    total++;
    if (nacc !== D) begin bad++; $display("FAIL bp_reads: got %0d accepted, required %0d", nacc, D); end
    step(1'b1, RWUnit, 10'h208, 64'h1122_3344_5566_7788, '1, 1'b0, acc);
    total++;
    if (acc !== 1'b1) begin bad++; $display("FAIL bp_write: got acc=%b, required 1", acc); end
    out_ready_i = 1'b1;
    step(1'b0, RefilUnit, 10'h208, '0, '0, 1'b0, acc);
    total++;
    if (acc !== 1'b1) begin bad++; $display("FAIL bp_resume: got acc=%b, required 1", acc); end
    drain("bp");
    total++;
    if (resp_n - r0 !== D + 1) begin bad++; $display("FAIL bp_count: got %0d responses, required %0d", resp_n - r0, D + 1); end
  endtask

  task automatic test_gnt_toggle();
    logic acc;
    int n = 0, guard = 0, gnt_off_acc = 0, r0;
    r0 = resp_n; out_ready_i = 1'b1;
    while (n < 10 && guard < 100) begin
      ram_gnt_i = ~ram_gnt_i;
      step(1'b0, UW'(n % 2), AW'(10'h300 + n), '0, '0, 1'b0, acc);
      if (acc && !ram_gnt_i) gnt_off_acc++;
      if (acc) n++;
      guard++;
    end
    ram_gnt_i = 1'b1;
    total++;
    if (n !== 10 || gnt_off_acc !== 0) begin
      bad++; $display("FAIL gnt_accepts: got %0d accepted, %0d without grant, required 10 and 0", n, gnt_off_acc);
    end
    drain("gnt");
    total++;
    if (resp_n - r0 !== 10) begin bad++; $display("FAIL gnt_count: got %0d responses, required 10", resp_n - r0); end
  endtask

  task automatic test_err();
    logic acc;
    int r0;
    r0 = resp_n;
    for (int i = 0; i < 5; i++) step(1'b0, EvictUnit, AW'(10'h3A0 + i), '0, '0, i == 2, acc);
    drain("err");
    total++;
    if (resp_n - r0 !== 5) begin bad++; $display("FAIL err_count: got %0d responses, required 5", resp_n - r0); end
  endtask

  task automatic test_interleave();
    logic acc;
    int r0;
    r0 = resp_n;
    step(1'b0, RefilUnit, 10'h20, '0, '0, 1'b0, acc);
    step(1'b1, RefilUnit, 10'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 1'b0, acc);
    step(1'b0, RWUnit, 10'h20, '0, '0, 1'b0, acc);
    step(1'b1, RWUnit, 10'h21, 64'h0123_4567_89AB_CDEF, 8'h0F, 1'b0, acc);
    step(1'b0, EvictUnit, 10'h21, '0, '0, 1'b0, acc);
    drain("ilv");
    total++;
    if (resp_n - r0 !== 3) begin bad++; $display("FAIL ilv_count: got %0d responses, required 3", resp_n - r0); end
  endtask

  task automatic test_reset_mid();
    logic acc;
    int r0, nacc = 0;
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, RefilUnit, AW'(10'h40 + i), '0, '0, 1'b0, acc);
      if (acc) nacc++;
    end
    total++;
    if ({nacc == 3, out_valid_o, busy_o} !== 3'b111) begin
      bad++; $display("FAIL mid_setup: got acc=%0d valid=%b busy=%b, required 3 1 1", nacc, out_valid_o, busy_o);
    end
    rst_ni = 1'b0; #1;
    total++;
    if ({out_valid_o, busy_o} !== 2'b00) begin
      bad++; $display("FAIL mid_reset: got valid=%b busy=%b, required 0 0", out_valid_o, busy_o);
    end
    sb.delete();
    repeat (2) @(posedge clk_i); #1;
    rst_ni = 1'b1; out_ready_i = 1'b1;
    r0 = resp_n;
    repeat (6) @(negedge clk_i);
    total++;
    if (resp_n !== r0) begin bad++; $display("FAIL mid_ghost: got %0d responses after release, required 0", resp_n - r0); end
    @(posedge clk_i); #1;
    step(1'b0, RefilUnit, 10'h10, '0, '0, 1'b0, acc);
    drain("mid");
    total++;
    if (resp_n - r0 !== 1) begin bad++; $display("FAIL mid_after: got %0d responses, required 1", resp_n - r0); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = pattern(i);
    fork
      monitor_rsp();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_gnt_toggle();
    test_err();
    test_interleave();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
